// File: rtl/imm_ext_stage.sv
// RV32I decode-stage immediate extractor with a 2-entry valid/ready skid buffer toward EX.
// Each entry carries the extended immediate, format code, PC and an illegal-opcode flag.
package imm_ext_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;

  localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
  localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [FMT_W-1:0] fmt;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } entry_t;

endpackage

module imm_ext_stage
  import imm_ext_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] IN_INSTR,
  input  logic [XLEN-1:0] IN_PC,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUT_IMM,
  output logic [2:0]      OUT_FMT,
  output logic [XLEN-1:0] OUT_PC,
  output logic            OUT_ILLEGAL
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } cnt_e;

  cnt_e   state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t dec;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   push, pop;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       sgn;

  assign opcode = IN_INSTR[6:0];
  assign funct3 = IN_INSTR[14:12];
  assign sgn    = IN_INSTR[31];

  // Input-side decode: format classification and immediate extension.
  always_comb begin
    dec         = '0;
    dec.pc      = IN_PC;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101)
          dec.imm = {27'b0, IN_INSTR[24:20]};
        else
          dec.imm = {{20{sgn}}, IN_INSTR[31:20]};
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
        dec.fmt = FMT_I;
        dec.imm = {{20{sgn}}, IN_INSTR[31:20]};
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = {{20{sgn}}, IN_INSTR[31:25], IN_INSTR[11:7]};
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        dec.imm = {{19{sgn}}, sgn, IN_INSTR[7], IN_INSTR[30:25], IN_INSTR[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        dec.imm = {IN_INSTR[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        dec.imm = {{11{sgn}}, sgn, IN_INSTR[19:12], IN_INSTR[20], IN_INSTR[30:21], 1'b0};
      end
      OPC_OP: begin
        dec.fmt = FMT_R;
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign push = IN_VALID & in_ready_q;
  assign pop  = out_valid_q & OUT_READY;

  // Occupancy next-state; the head register is the output, the tail is the skid slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (FLUSH) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          case ({push, pop})
            2'b11: head_d = dec;
            2'b10: begin
              tail_d  = dec;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            default: state_d = ONE;
          endcase
        end
        FULL: begin
          // IN_READY is low here, so only a pop can occur.
          if (pop) begin
            head_d  = tail_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign IN_READY    = in_ready_q;
  assign OUT_VALID   = out_valid_q;
  assign OUT_IMM     = head_q.imm;
  assign OUT_FMT     = head_q.fmt;
  assign OUT_PC      = head_q.pc;
  assign OUT_ILLEGAL = head_q.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: decode vector table, directed buffer corner cases,
// then randomized traffic against a queue-based reference model.
module tb_imm_ext_stage;

  logic        CLK;
  logic        RESET;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_INSTR;
  logic [31:0] IN_PC;
  logic        FLUSH;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_IMM;
  logic [2:0]  OUT_FMT;
  logic [31:0] OUT_PC;
  logic        OUT_ILLEGAL;

  int checks = 0;
  int errors = 0;

  imm_ext_stage dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_INSTR(IN_INSTR), .IN_PC(IN_PC), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_IMM(OUT_IMM), .OUT_FMT(OUT_FMT), .OUT_PC(OUT_PC),
    .OUT_ILLEGAL(OUT_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] pc;
  } ent_t;

  vec_t vecs[13];
  ent_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Reference decode from the RV32I field definitions using integer arithmetic.
  function automatic void ref_decode(input logic [31:0] ins, output logic [31:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    int s;
    int hi;
    logic [6:0] opc;
    int f3;
    s   = $signed(ins);
    hi  = s >>> 31;
    opc = ins[6:0];
    f3  = int'((ins >> 12) & 7);
    ill = 1'b0;
    imm = 32'h0;
    fmt = 3'd7;
    case (opc)
      7'h13: begin
        fmt = 3'd1;
        imm = (f3 == 1 || f3 == 5) ? ((ins >> 20) & 32'd31) : 32'(s >>> 20);
      end
      7'h03, 7'h67, 7'h73: begin
        fmt = 3'd1;
        imm = 32'(s >>> 20);
      end
      7'h23: begin
        fmt = 3'd2;
        imm = 32'((s >>> 25) * 32 + int'((ins >> 7) & 31));
      end
      7'h63: begin
        fmt = 3'd3;
        imm = 32'(hi * 4096 + int'((ins >> 7) & 1) * 2048 + int'((ins >> 25) & 63) * 32
                  + int'((ins >> 8) & 15) * 2);
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        imm = ins & 32'hFFFFF000;
      end
      7'h6F: begin
        fmt = 3'd5;
        imm = 32'(hi * 1048576 + int'((ins >> 12) & 255) * 4096 + int'((ins >> 20) & 1) * 2048
                  + int'((ins >> 21) & 1023) * 2);
      end
      7'h33: fmt = 3'd0;
      default: begin
        fmt = 3'd7;
        ill = 1'b1;
      end
    endcase
  endfunction

  initial begin
    logic [6:0]  opcs[10];
    logic [31:0] r;
    ent_t        e;
    int          sz;

    opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    vecs[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE20AE23, 32'h104, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'h40515093, 32'h108, 32'h00000005, 3'd1, 1'b0};
    vecs[3]  = '{32'hFE000CE3, 32'h10C, 32'hFFFFFFF8, 3'd3, 1'b0};
    vecs[4]  = '{32'h123452B7, 32'h110, 32'h12345000, 3'd4, 1'b0};
    vecs[5]  = '{32'h0080006F, 32'h114, 32'h00000008, 3'd5, 1'b0};
    vecs[6]  = '{32'h00B50533, 32'h118, 32'h00000000, 3'd0, 1'b0};
    vecs[7]  = '{32'h0000007F, 32'h11C, 32'h00000000, 3'd7, 1'b1};
    vecs[8]  = '{32'h00412083, 32'h120, 32'h00000004, 3'd1, 1'b0};
    vecs[9]  = '{32'hFFF01093, 32'h124, 32'h0000001F, 3'd1, 1'b0};
    vecs[10] = '{32'h00000073, 32'h128, 32'h00000000, 3'd1, 1'b0};
    vecs[11] = '{32'hFFFFF517, 32'h12C, 32'hFFFFF000, 3'd4, 1'b0};
    vecs[12] = '{32'h80000067, 32'h130, 32'hFFFFF800, 3'd1, 1'b0};

    CLK = 1'b0;
    RESET = 1'b1;
    IN_VALID = 1'b0;
    IN_INSTR = 32'h0;
    IN_PC = 32'h0;
    FLUSH = 1'b0;
    OUT_READY = 1'b0;

    // Reset state
    @(posedge CLK);
    tick();
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_imm", OUT_IMM, 32'h0);
    chk("rst_fmt", 32'(OUT_FMT), 32'd0);
    chk("rst_pc", OUT_PC, 32'h0);
    chk("rst_ill", 32'(OUT_ILLEGAL), 32'd0);
    RESET = 1'b0;
    tick();

    // Decode table, one instruction at a time with EX always ready
    for (int i = 0; i < 13; i++) begin
      IN_VALID = 1'b1;
      IN_INSTR = vecs[i].instr;
      IN_PC = vecs[i].pc;
      OUT_READY = 1'b1;
      tick();
      IN_VALID = 1'b0;
      chk($sformatf("tbl%0d_valid", i), 32'(OUT_VALID), 32'd1);
      chk($sformatf("tbl%0d_imm", i), OUT_IMM, vecs[i].imm);
      chk($sformatf("tbl%0d_fmt", i), 32'(OUT_FMT), 32'(vecs[i].fmt));
      chk($sformatf("tbl%0d_pc", i), OUT_PC, vecs[i].pc);
      chk($sformatf("tbl%0d_ill", i), 32'(OUT_ILLEGAL), 32'(vecs[i].ill));
      tick();
    end
    chk("tbl_drained", 32'(OUT_VALID), 32'd0);

    // Backpressure: three back-to-back with EX stalled
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    IN_INSTR = 32'h00100093;
    IN_PC = 32'h200;
    tick();
    chk("bp_ready1", 32'(IN_READY), 32'd1);
    chk("bp_valid1", 32'(OUT_VALID), 32'd1);
    IN_INSTR = 32'h00200093;
    IN_PC = 32'h204;
    tick();
    chk("bp_ready_full", 32'(IN_READY), 32'd0);
    chk("bp_head_a", OUT_IMM, 32'd1);
    IN_INSTR = 32'h00300093;
    IN_PC = 32'h208;
    tick();
    chk("bp_still_full", 32'(IN_READY), 32'd0);
    chk("bp_hold_imm", OUT_IMM, 32'd1);
    chk("bp_hold_pc", OUT_PC, 32'h200);
    OUT_READY = 1'b1;
    tick();
    chk("bp_head_b_imm", OUT_IMM, 32'd2);
    chk("bp_head_b_pc", OUT_PC, 32'h204);
    chk("bp_ready_again", 32'(IN_READY), 32'd1);
    tick();
    chk("bp_head_c_imm", OUT_IMM, 32'd3);
    chk("bp_head_c_pc", OUT_PC, 32'h208);
    chk("bp_head_c_valid", 32'(OUT_VALID), 32'd1);
    IN_VALID = 1'b0;
    tick();
    chk("bp_empty", 32'(OUT_VALID), 32'd0);

    // Flush while full with a concurrent push
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    IN_INSTR = 32'h00500093;
    tick();
    tick();
    chk("fl_full", 32'(IN_READY), 32'd0);
    FLUSH = 1'b1;
    OUT_READY = 1'b1;
    tick();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    chk("fl_valid", 32'(OUT_VALID), 32'd0);
    chk("fl_ready", 32'(IN_READY), 32'd1);
    tick();
    chk("fl_nothing", 32'(OUT_VALID), 32'd0);

    // Illegal entry stalled, then reset mid-stall
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    IN_INSTR = 32'h0000007F;
    IN_PC = 32'h300;
    tick();
    IN_INSTR = 32'h00100093;
    IN_PC = 32'h304;
    tick();
    IN_VALID = 1'b0;
    chk("il_valid", 32'(OUT_VALID), 32'd1);
    chk("il_fmt", 32'(OUT_FMT), 32'd7);
    chk("il_flag", 32'(OUT_ILLEGAL), 32'd1);
    chk("il_imm", OUT_IMM, 32'h0);
    chk("il_pc", OUT_PC, 32'h300);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("ir_valid", 32'(OUT_VALID), 32'd0);
    chk("ir_ready", 32'(IN_READY), 32'd1);
    chk("ir_imm", OUT_IMM, 32'h0);
    chk("ir_fmt", 32'(OUT_FMT), 32'd0);
    chk("ir_pc", OUT_PC, 32'h0);
    chk("ir_ill", 32'(OUT_ILLEGAL), 32'd0);

    // Randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 800; c++) begin
      chk("rnd_valid", 32'(OUT_VALID), 32'(q.size() != 0));
      chk("rnd_ready", 32'(IN_READY), 32'(q.size() != 2));
      if (q.size() != 0) begin
        chk("rnd_imm", OUT_IMM, q[0].imm);
        chk("rnd_fmt", 32'(OUT_FMT), 32'(q[0].fmt));
        chk("rnd_pc", OUT_PC, q[0].pc);
        chk("rnd_ill", 32'(OUT_ILLEGAL), 32'(q[0].ill));
      end
      r = $urandom();
      if ($urandom_range(0, 7) == 0) IN_INSTR = r;
      else IN_INSTR = {r[31:7], opcs[$urandom_range(0, 9)]};
      IN_PC = $urandom();
      IN_VALID = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      FLUSH = ($urandom_range(0, 39) == 0);
      RESET = ($urandom_range(0, 99) == 0);
      if (RESET || FLUSH) begin
        q.delete();
      end else begin
        sz = q.size();
        if (OUT_READY && sz > 0) void'(q.pop_front());
        if (IN_VALID && sz < 2) begin
          ref_decode(IN_INSTR, e.imm, e.fmt, e.ill);
          e.pc = IN_PC;
          q.push_back(e);
        end
      end
      tick();
    end
    RESET = 1'b0;
    FLUSH = 1'b0;
    IN_VALID = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
